// File: rtl/branch_resolve_if.sv
// Predictor-update channel from branch_resolve.
// Valid/ready handshake carrying one resolved branch.
interface branch_resolve_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [1:0]  upd_state;

  modport master (
    output upd_valid,
    output upd_pc,
    output upd_target,
    output upd_taken,
    output upd_state,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_pc,
    input  upd_target,
    input  upd_taken,
    input  upd_state,
    output upd_ready
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: redirect on mispredict,
// queue predictor updates in a small FIFO.
module branch_resolve #(
  parameter int UPD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic [1:0]  ex_bp_state,
  output logic        stall_ex,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  branch_resolve_if.master upd
);

  localparam int PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RECOVER} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic [1:0]  st;
  } upd_ent_t;

  state_t state_q, state_d;

  upd_ent_t       mem [UPD_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic        is_cf;
  logic        fifo_full;
  logic        resolve;
  logic        push, pop;
  logic        cond_true;
  logic        act_taken;
  logic [31:0] act_target;
  logic [31:0] jalr_sum;
  logic [31:0] corr_pc;
  logic        mispred;
  logic [1:0]  new_state;
  upd_ent_t    head;

  assign is_cf     = ex_is_branch | ex_is_jal | ex_is_jalr;
  assign fifo_full = (count == CW'(UPD_DEPTH));
  assign stall_ex  = fifo_full & ex_valid & is_cf
                   & (state_q == IDLE);
  assign resolve   = ex_valid & is_cf
                   & (state_q == IDLE) & ~stall_ex;
  assign push      = resolve;
  assign pop       = upd.upd_valid & upd.upd_ready;
  assign jalr_sum  = rs1_val + ex_imm;

  // Branch condition from funct3; reserved codes fall through not-taken.
  always_comb begin
    cond_true = 1'b0;
    case (ex_funct3)
      3'b000:  cond_true = (rs1_val == rs2_val);
      3'b001:  cond_true = (rs1_val != rs2_val);
      3'b100:  cond_true = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  cond_true = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond_true = (rs1_val < rs2_val);
      3'b111:  cond_true = (rs1_val >= rs2_val);
      default: cond_true = 1'b0;
    endcase
  end

  // Actual direction and target by control-flow class.
  always_comb begin
    act_taken  = 1'b0;
    act_target = ex_pc + ex_imm;
    unique case (1'b1)
      ex_is_jal:    act_taken = 1'b1;
      ex_is_jalr: begin
        act_taken  = 1'b1;
        act_target = {jalr_sum[31:1], 1'b0};
      end
      ex_is_branch: act_taken = cond_true;
      default:      act_taken = 1'b0;
    endcase
  end

  // Mispredict test, corrected PC and saturating counter update.
  always_comb begin
    mispred = (act_taken != ex_pred_taken)
            | (act_taken & ex_pred_taken
               & (act_target != ex_pred_target));
    corr_pc = act_taken ? act_target : ex_pc + 32'd4;
    if (act_taken)
      new_state = (ex_bp_state == 2'd3) ? 2'd3
                : ex_bp_state + 2'd1;
    else
      new_state = (ex_bp_state == 2'd0) ? 2'd0
                : ex_bp_state - 2'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: one RECOVER cycle after a mispredict.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (resolve && mispred) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign redirect_valid = (state_q == RECOVER);
  assign flush_if_id    = redirect_valid;
  assign flush_id_ex    = redirect_valid;

  // Latch the corrected PC for the following RECOVER cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 redirect_pc <= 32'd0;
    else if (resolve && mispred) redirect_pc <= corr_pc;
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: ex_pc, tgt: act_target,
                               tk: act_taken, st: new_state};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head           = mem[rd_ptr];
  assign upd.upd_valid  = (count != '0);
  assign upd.upd_pc     = head.pc;
  assign upd.upd_target = head.tgt;
  assign upd.upd_taken  = head.tk;
  assign upd.upd_state  = head.st;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve:
// directed scenarios plus a randomized run against a queue model.
module tb_branch_resolve;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] ex_imm = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic [1:0]  ex_bp_state = '0;
  logic        stall_ex;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;

  int n_chk = 0;
  int n_fail = 0;

  branch_resolve_if bus();

  branch_resolve #(.UPD_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_bp_state    (ex_bp_state),
    .stall_ex       (stall_ex),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .upd            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic [1:0]  st;
  } upd_t;

  // kind: 0 none, 1 branch, 2 jal, 3 jalr
  function automatic logic m_taken(int kind, logic [2:0] f3,
                                   logic [31:0] a, logic [31:0] b);
    if (kind >= 2) return 1'b1;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(int kind, logic [31:0] pc,
                                           logic [31:0] a,
                                           logic [31:0] imm);
    if (kind == 3) return (a + imm) & 32'hFFFF_FFFE;
    return pc + imm;
  endfunction

  function automatic logic [1:0] m_state(logic t, logic [1:0] bs);
    int s;
    s = int'(bs) + (t ? 1 : -1);
    if (s > 3) s = 3;
    if (s < 0) s = 0;
    return 2'(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_valid = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jal = 1'b0;
    ex_is_jalr = 1'b0;
  endtask

  task automatic drive(input int kind, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt,
                       input logic [1:0] bs);
    ex_valid = 1'b1;
    ex_is_branch = (kind == 1);
    ex_is_jal = (kind == 2);
    ex_is_jalr = (kind == 3);
    ex_funct3 = f3;
    ex_pc = pc;
    rs1_val = a;
    rs2_val = b;
    ex_imm = imm;
    ex_pred_taken = pt;
    ex_pred_target = ptgt;
    ex_bp_state = bs;
  endtask

  task automatic do_reset;
    idle();
    bus.upd_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    bus.upd_ready = 1'b1;
    rst = 1'b0;
    drive(1, 3'd0, 32'h100, 5, 5, 32'h20, 1'b0, 0, 2'd1);
    #1;
    n_chk++;
    if (stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall: got %b want 0", stall_ex);
    end
    tick(); tick();
    n_chk++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0
        || flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_redirect: got %b%b%b want 000",
               redirect_valid, flush_if_id, flush_id_ex);
    end
    n_chk++;
    if (redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rpc: got %h want 0", redirect_pc);
    end
    n_chk++;
    if (bus.upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_upd_valid: got %b want 0", bus.upd_valid);
    end
    idle();
    rst = 1'b1;
    tick();
    n_chk++;
    if (bus.upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got %b%b want 00",
               bus.upd_valid, redirect_valid);
    end
  endtask

  task automatic test_beq_mispredict;
    do_reset();
    drive(1, 3'd0, 32'h100, 5, 5, 32'h20, 1'b0, 0, 2'd1);
    #1;
    n_chk++;
    if (stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_stall: got %b want 0", stall_ex);
    end
    tick();
    idle();
    n_chk++;
    if (redirect_valid !== 1'b1 || flush_if_id !== 1'b1
        || flush_id_ex !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_redirect: got %b%b%b want 111",
               redirect_valid, flush_if_id, flush_id_ex);
    end
    n_chk++;
    if (redirect_pc !== 32'h120) begin
      n_fail++;
      $display("FAIL beq_rpc: got %h want 120", redirect_pc);
    end
    n_chk++;
    if (bus.upd_valid !== 1'b1 || bus.upd_taken !== 1'b1
        || bus.upd_state !== 2'd2 || bus.upd_pc !== 32'h100
        || bus.upd_target !== 32'h120) begin
      n_fail++;
      $display("FAIL beq_upd: got v%b t%b s%0d pc%h tg%h want 1 1 2 100 120",
               bus.upd_valid, bus.upd_taken, bus.upd_state,
               bus.upd_pc, bus.upd_target);
    end
    tick();
    n_chk++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0
        || flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_one_cycle: got %b%b%b want 000",
               redirect_valid, flush_if_id, flush_id_ex);
    end
  endtask

  task automatic test_bne_saturate;
    do_reset();
    drive(1, 3'd1, 32'h40, 7, 7, 32'h8, 1'b0, 0, 2'd0);
    tick();
    idle();
    n_chk++;
    if (redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_redirect: got %b want 0", redirect_valid);
    end
    n_chk++;
    if (bus.upd_valid !== 1'b1 || bus.upd_taken !== 1'b0
        || bus.upd_state !== 2'd0 || bus.upd_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL bne_upd: got v%b t%b s%0d pc%h want 1 0 0 40",
               bus.upd_valid, bus.upd_taken, bus.upd_state, bus.upd_pc);
    end
  endtask

  task automatic test_jalr;
    do_reset();
    drive(3, 3'd0, 32'h200, 32'h1003, 0, 32'h10, 1'b1, 32'h1012, 2'd2);
    tick();
    idle();
    n_chk++;
    if (redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_hit_redirect: got %b want 0", redirect_valid);
    end
    n_chk++;
    if (bus.upd_target !== 32'h1012 || bus.upd_state !== 2'd3) begin
      n_fail++;
      $display("FAIL jalr_upd: got tg%h s%0d want 1012 3",
               bus.upd_target, bus.upd_state);
    end
    drive(3, 3'd0, 32'h200, 32'h1003, 0, 32'h10, 1'b1, 32'h1000, 2'd2);
    tick();
    idle();
    n_chk++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1012) begin
      n_fail++;
      $display("FAIL jalr_miss: got v%b pc%h want 1 1012",
               redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_back_to_back_stall;
    do_reset();
    drive(1, 3'd0, 32'h10, 1, 2, 32'h8, 1'b0, 0, 2'd1);
    #1;
    n_chk++;
    if (stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall_a: got %b want 0", stall_ex);
    end
    tick();
    drive(1, 3'd0, 32'h14, 1, 2, 32'h8, 1'b0, 0, 2'd1);
    #1;
    n_chk++;
    if (stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall_b: got %b want 0", stall_ex);
    end
    tick();
    drive(1, 3'd0, 32'h18, 1, 2, 32'h8, 1'b0, 0, 2'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (stall_ex !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_stall_c%0d: got %b want 1", i, stall_ex);
      end
      tick();
    end
    bus.upd_ready = 1'b1;
    #1;
    n_chk++;
    if (stall_ex !== 1'b1 || bus.upd_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL b2b_head_a: got st%b pc%h want 1 10",
               stall_ex, bus.upd_pc);
    end
    tick();
    bus.upd_ready = 1'b0;
    #1;
    n_chk++;
    if (stall_ex !== 1'b0 || bus.upd_pc !== 32'h14) begin
      n_fail++;
      $display("FAIL b2b_head_b: got st%b pc%h want 0 14",
               stall_ex, bus.upd_pc);
    end
    tick();
    idle();
    bus.upd_ready = 1'b1;
    tick();
    n_chk++;
    if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h18) begin
      n_fail++;
      $display("FAIL b2b_head_c: got v%b pc%h want 1 18",
               bus.upd_valid, bus.upd_pc);
    end
    tick();
    n_chk++;
    if (bus.upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: got %b want 0", bus.upd_valid);
    end
    bus.upd_ready = 1'b0;
  endtask

  task automatic test_recover_ignore;
    do_reset();
    drive(1, 3'd0, 32'h300, 9, 9, 32'h40, 1'b0, 0, 2'd1);
    tick();
    drive(1, 3'd0, 32'h304, 9, 9, 32'h40, 1'b0, 0, 2'd1);
    #1;
    n_chk++;
    if (redirect_valid !== 1'b1 || stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL rec_first: got v%b st%b want 1 0",
               redirect_valid, stall_ex);
    end
    tick();
    idle();
    n_chk++;
    if (redirect_valid !== 1'b0 || bus.upd_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL rec_ignored: got v%b pc%h want 0 300",
               redirect_valid, bus.upd_pc);
    end
    bus.upd_ready = 1'b1;
    tick();
    bus.upd_ready = 1'b0;
    n_chk++;
    if (bus.upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rec_count: got %b want 0", bus.upd_valid);
    end
  endtask

  task automatic test_reset_mid_recover;
    do_reset();
    drive(1, 3'd0, 32'h500, 1, 2, 32'h40, 1'b0, 0, 2'd1);
    tick();
    drive(1, 3'd0, 32'h504, 3, 3, 32'h40, 1'b0, 0, 2'd1);
    tick();
    idle();
    n_chk++;
    if (redirect_valid !== 1'b1 || bus.upd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got v%b u%b want 1 1",
               redirect_valid, bus.upd_valid);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (redirect_valid !== 1'b0 || bus.upd_valid !== 1'b0
        || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got v%b u%b want 0 0",
               redirect_valid, bus.upd_valid);
    end
    tick();
    rst = 1'b1;
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (redirect_valid !== 1'b0 || bus.upd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after%0d: got v%b u%b want 0 0",
                 i, redirect_valid, bus.upd_valid);
      end
    end
    bus.upd_ready = 1'b0;
  endtask

  task automatic test_random;
    upd_t        q[$];
    upd_t        e;
    logic        rec;
    logic [31:0] exp_rpc;
    int          kind;
    logic        ev, t, pt, cf, exp_stall, res, mis;
    logic [31:0] pc, a, b, imm, tg, ptgt, r;
    logic [2:0]  f3;
    logic [1:0]  bs;
    do_reset();
    rec = 1'b0;
    exp_rpc = '0;
    for (int c = 0; c < 600; c++) begin
      ev = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      f3 = 3'($urandom);
      pc = $urandom & 32'hFFFF_FFFC;
      a = ($urandom_range(0, 1) != 0) ? 32'd5 : $urandom;
      b = ($urandom_range(0, 1) != 0) ? 32'd5 : $urandom;
      r = $urandom;
      imm = {{20{r[11]}}, r[11:0]};
      pt = 1'($urandom);
      bs = 2'($urandom);
      t = m_taken(kind, f3, a, b);
      tg = m_target(kind, pc, a, imm);
      ptgt = ($urandom_range(0, 2) != 0) ? tg : $urandom;
      if (ev) drive(kind, f3, pc, a, b, imm, pt, ptgt, bs);
      else idle();
      bus.upd_ready = ($urandom_range(0, 2) == 0);
      #1;
      cf = ev && (kind != 0);
      exp_stall = cf && !rec && (q.size() == DEPTH);
      res = cf && !rec && !exp_stall;
      n_chk++;
      if (stall_ex !== exp_stall) begin
        n_fail++;
        $display("FAIL rnd_stall c%0d: got %b want %b",
                 c, stall_ex, exp_stall);
      end
      n_chk++;
      if (redirect_valid !== rec || flush_if_id !== rec
          || flush_id_ex !== rec) begin
        n_fail++;
        $display("FAIL rnd_redirect c%0d: got %b%b%b want %b",
                 c, redirect_valid, flush_if_id, flush_id_ex, rec);
      end
      if (rec) begin
        n_chk++;
        if (redirect_pc !== exp_rpc) begin
          n_fail++;
          $display("FAIL rnd_rpc c%0d: got %h want %h",
                   c, redirect_pc, exp_rpc);
        end
      end
      n_chk++;
      if (bus.upd_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_upd_valid c%0d: got %b want %b",
                 c, bus.upd_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_chk++;
        if (bus.upd_pc !== q[0].pc || bus.upd_target !== q[0].tgt
            || bus.upd_taken !== q[0].tk
            || bus.upd_state !== q[0].st) begin
          n_fail++;
          $display("FAIL rnd_head c%0d: got %h %h %b %0d want %h %h %b %0d",
                   c, bus.upd_pc, bus.upd_target, bus.upd_taken,
                   bus.upd_state, q[0].pc, q[0].tgt, q[0].tk, q[0].st);
        end
      end
      if (q.size() != 0 && bus.upd_ready) void'(q.pop_front());
      mis = 1'b0;
      if (res) begin
        e.pc = pc;
        e.tgt = tg;
        e.tk = t;
        e.st = m_state(t, bs);
        q.push_back(e);
        mis = (t != pt) || (t && pt && tg != ptgt);
        if (mis) exp_rpc = t ? tg : pc + 32'd4;
      end
      rec = res && mis;
      tick();
    end
    idle();
    bus.upd_ready = 1'b0;
  endtask

  initial begin
    bus.upd_ready = 1'b0;
    #1;
    test_reset();
    test_beq_mispredict();
    test_bne_saturate();
    test_jalr();
    test_back_to_back_stall();
    test_recover_ignore();
    test_reset_mid_recover();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
